// File: rtl/aes_batch_scheduler.sv
// Packs plaintext/key blocks into the N lanes of the AES engine,
// launches it, then streams the captured ciphertexts out in order.
module aes_batch_scheduler #(
  parameter int N = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_text,
  input  logic [127:0]     in_key,
  input  logic             in_last,
  output logic             aes_start,
  output logic [128*N-1:0] aes_plain_text,
  output logic [128*N-1:0] aes_cipher_key,
  input  logic             aes_done,
  input  logic [128*N-1:0] aes_cipher_text,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] FILL   = 2'd0;
  localparam logic [1:0] LAUNCH = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] DRAIN  = 2'd3;

  localparam logic [CW-1:0] LANE_TOP = CW'(N - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] idx;
  logic [CW-1:0] last_idx;

  logic [127:0] txt_q [N];
  logic [127:0] key_q [N];
  logic [127:0] res_q [N];

  logic in_hs;
  logic out_hs;
  logic fill_end;
  logic drain_end;

  assign in_hs     = in_valid && (state == FILL);
  assign out_hs    = out_ready && (state == DRAIN);
  assign last_idx  = cnt - CW'(1);
  assign fill_end  = in_last || (cnt == LANE_TOP);
  assign drain_end = (idx == last_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      unique case (state)
        FILL: begin
          if (in_hs) begin
            cnt <= cnt + CW'(1);
            if (fill_end) state <= LAUNCH;
          end
        end
        LAUNCH: begin
          state <= WAIT;
        end
        WAIT: begin
          if (aes_done) begin
            state <= DRAIN;
            idx   <= '0;
          end
        end
        DRAIN: begin
          if (out_hs) begin
            if (drain_end) begin
              state <= FILL;
              cnt   <= '0;
              idx   <= '0;
            end else begin
              idx <= idx + CW'(1);
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  // An early in_last zeroes every lane above the one just written,
  // so no stale data from an older batch reaches the engine.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        txt_q[i] <= '0;
        key_q[i] <= '0;
      end
    end else if (in_hs) begin
      for (int i = 0; i < N; i++) begin
        if (CW'(i) == cnt) begin
          txt_q[i] <= in_text;
          key_q[i] <= in_key;
        end else if (in_last && (CW'(i) > cnt)) begin
          txt_q[i] <= '0;
          key_q[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) res_q[i] <= '0;
    end else if ((state == WAIT) && aes_done) begin
      for (int i = 0; i < N; i++) begin
        res_q[i] <= aes_cipher_text[128*i +: 128];
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_bus
    assign aes_plain_text[128*g +: 128] = txt_q[g];
    assign aes_cipher_key[128*g +: 128] = key_q[g];
  end

  always_comb begin
    out_data = '0;
    for (int i = 0; i < N; i++) begin
      if ((state == DRAIN) && (idx == CW'(i))) out_data = res_q[i];
    end
  end

  assign in_ready  = (state == FILL);
  assign aes_start = (state == LAUNCH);
  assign out_valid = (state == DRAIN);
  assign out_last  = out_valid && drain_end;
  assign busy      = (state != FILL);

endmodule

// File: tb/tb_aes_batch_scheduler.sv
// Scoreboard bench for aes_batch_scheduler with a behavioural
// engine model that knows the FIPS-197 AES-128 known answer.
`timescale 1ns/1ps
module tb_aes_batch_scheduler;

  localparam int N = 4;
  localparam int W = 128 * N;

  localparam logic [127:0] KPT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KKEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KCT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [127:0]   in_text = '0;
  logic [127:0]   in_key = '0;
  logic           in_last = 1'b0;
  logic           aes_start;
  logic [W-1:0]   aes_plain_text;
  logic [W-1:0]   aes_cipher_key;
  logic           aes_done;
  logic [W-1:0]   aes_cipher_text;
  logic           out_valid;
  logic           out_ready;
  logic [127:0]   out_data;
  logic           out_last;
  logic           busy;

  logic           eng_auto = 1'b1;
  logic           eng_done = 1'b0;
  logic [W-1:0]   eng_ct = '0;
  int             eng_wait = 0;
  logic           man_done = 1'b0;
  logic [W-1:0]   man_ct = '0;
  logic           rdy_toggle = 1'b0;
  logic           rdy_hold = 1'b1;
  logic           tog = 1'b0;

  logic [128:0]   exp_q[$];
  logic [128:0]   got_q[$];
  int             bcnt = 0;
  int             n_checks = 0;
  int             n_fail = 0;

  aes_batch_scheduler #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_text(in_text), .in_key(in_key), .in_last(in_last),
    .aes_start(aes_start),
    .aes_plain_text(aes_plain_text),
    .aes_cipher_key(aes_cipher_key),
    .aes_done(aes_done), .aes_cipher_text(aes_cipher_text),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] enc(input logic [127:0] p, input logic [127:0] k);
    if (p == KPT && k == KKEY) return KCT;
    return {p[63:0], p[127:64]} ^ k ^ 128'h5a5a_0f0f_a5a5_f0f0_1234_5678_9abc_def0;
  endfunction

  // Engine model: fixed latency, done stays high until the next start.
  always @(posedge clk) begin
    if (aes_start) begin
      eng_wait <= 3;
      eng_done <= 1'b0;
    end else if (eng_wait == 1) begin
      eng_done <= 1'b1;
      eng_wait <= 0;
      for (int i = 0; i < N; i++)
        eng_ct[128*i +: 128] <= enc(aes_plain_text[128*i +: 128], aes_cipher_key[128*i +: 128]);
    end else if (eng_wait > 1) begin
      eng_wait <= eng_wait - 1;
    end
  end

  assign aes_done        = eng_auto ? eng_done : man_done;
  assign aes_cipher_text = eng_auto ? eng_ct : man_ct;

  always @(posedge clk) tog <= ~tog;
  assign out_ready = rdy_toggle ? tog : rdy_hold;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) got_q.push_back({out_last, out_data});
  end

  task automatic send_block(input logic [127:0] t, input logic [127:0] k, input logic last);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_text = t;
    in_key = k;
    in_last = last;
    for (int c = 0; c < 100 && !acc; c++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    n_checks++;
    if (!acc) begin
      n_fail++;
      $display("FAIL send_timeout in_ready never high, required 1");
    end else begin
      bcnt++;
      exp_q.push_back({(last || bcnt == N), enc(t, k)});
      if (last || bcnt == N) bcnt = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle(2);
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++; if (aes_start !== 1'b0) begin n_fail++; $display("FAIL reset_start got %b want 0", aes_start); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last got %b want 0", out_last); end
    n_checks++; if (out_data !== 128'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (aes_plain_text !== '0) begin n_fail++; $display("FAIL reset_lanes got %h want 0", aes_plain_text); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    got_q.delete();
    bcnt = 0;
  endtask

  task automatic test_full_batch;
    logic [128:0] g;
    rdy_hold = 1'b1;
    for (int i = 0; i < N; i++) begin
      send_block(KPT, KKEY, 1'b0);
      if (i < N - 1) begin
        n_checks++;
        if (aes_start !== 1'b0) begin n_fail++; $display("FAIL full_early_start blk %0d got %b want 0", i, aes_start); end
      end
    end
    n_checks++; if (aes_start !== 1'b1) begin n_fail++; $display("FAIL full_start got %b want 1", aes_start); end
    idle(1);
    n_checks++; if (aes_start !== 1'b0) begin n_fail++; $display("FAIL full_start_width got %b want 0", aes_start); end
    for (int c = 0; c < 200 && got_q.size() < N; c++) @(posedge clk);
    n_checks++;
    if (got_q.size() != N) begin n_fail++; $display("FAIL full_count got %0d want %0d", got_q.size(), N); end
    for (int i = 0; got_q.size() > 0; i++) begin
      g = got_q.pop_front();
      n_checks++;
      if (g !== {(i == N - 1), KCT}) begin n_fail++; $display("FAIL full_out %0d got %h want %h", i, g, {(i == N - 1), KCT}); end
    end
    exp_q.delete();
  endtask

  task automatic test_partial;
    logic [127:0] t0, t1, k0, k1;
    logic [128:0] e, g;
    t0 = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677;
    t1 = 128'hfedc_ba98_7654_3210_8899_aabb_ccdd_eeff;
    k0 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    k1 = 128'h9999_aaaa_bbbb_cccc_dddd_eeee_ffff_0000;
    send_block(t0, k0, 1'b0);
    send_block(t1, k1, 1'b1);
    n_checks++; if (aes_plain_text[W-1:256] !== '0) begin n_fail++; $display("FAIL partial_pad_text got %h want 0", aes_plain_text[W-1:256]); end
    n_checks++; if (aes_cipher_key[W-1:256] !== '0) begin n_fail++; $display("FAIL partial_pad_key got %h want 0", aes_cipher_key[W-1:256]); end
    n_checks++; if (aes_plain_text[255:0] !== {t1, t0}) begin n_fail++; $display("FAIL partial_lanes got %h want %h", aes_plain_text[255:0], {t1, t0}); end
    for (int c = 0; c < 200 && got_q.size() < 2; c++) @(posedge clk);
    idle(10);
    n_checks++;
    if (got_q.size() != 2) begin n_fail++; $display("FAIL partial_count got %0d want 2", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL partial_out got %h want %h", g, e); end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_backpressure;
    logic [128:0] e, g;
    logic stalled;
    logic [127:0] pd;
    logic pl;
    int bad_rdy, bad_hold;
    stalled = 1'b0;
    pd = '0;
    pl = 1'b0;
    bad_rdy = 0;
    bad_hold = 0;
    rdy_toggle = 1'b1;
    for (int i = 0; i < N; i++) begin
      idle($urandom_range(0, 3));
      send_block({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    end
    for (int c = 0; c < 300 && got_q.size() < N; c++) begin
      @(negedge clk);
      if (busy && in_ready !== 1'b0) bad_rdy++;
      if (stalled && (out_data !== pd || out_last !== pl)) bad_hold++;
      stalled = out_valid && !out_ready;
      pd = out_data;
      pl = out_last;
    end
    n_checks++; if (bad_rdy != 0) begin n_fail++; $display("FAIL bp_in_ready high while busy %0d cycles, want 0", bad_rdy); end
    n_checks++; if (bad_hold != 0) begin n_fail++; $display("FAIL bp_stall_stable changed %0d times, want 0", bad_hold); end
    @(posedge clk);
    n_checks++;
    if (got_q.size() != N) begin n_fail++; $display("FAIL bp_count got %0d want %0d", got_q.size(), N); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL bp_out got %h want %h", g, e); end
    end
    exp_q.delete();
    got_q.delete();
    rdy_toggle = 1'b0;
    idle(2);
  endtask

  task automatic test_stale_done;
    logic [127:0] t[N];
    logic [127:0] k[N];
    logic [128:0] e, g;
    int bad_wait;
    bad_wait = 0;
    eng_auto = 1'b0;
    man_done = 1'b0;
    for (int i = 0; i < N; i++) begin
      t[i] = {$urandom, $urandom, $urandom, $urandom};
      k[i] = {$urandom, $urandom, $urandom, $urandom};
      man_ct[128*i +: 128] = ~enc(t[i], k[i]);
    end
    for (int i = 0; i < N; i++) send_block(t[i], k[i], 1'b0);
    man_done = 1'b1;
    idle(1);
    man_done = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0 || aes_start !== 1'b0) bad_wait++;
    end
    n_checks++; if (bad_wait != 0) begin n_fail++; $display("FAIL stale_wait left WAIT in %0d cycles, want 0", bad_wait); end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) man_ct[128*i +: 128] = enc(t[i], k[i]);
    man_done = 1'b1;
    idle(1);
    man_done = 1'b0;
    for (int c = 0; c < 100 && got_q.size() < N; c++) @(posedge clk);
    n_checks++;
    if (got_q.size() != N) begin n_fail++; $display("FAIL stale_count got %0d want %0d", got_q.size(), N); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL stale_out got %h want %h", g, e); end
    end
    exp_q.delete();
    got_q.delete();
    eng_auto = 1'b1;
    idle(2);
  endtask

  task automatic test_reset_mid;
    logic [128:0] e, g;
    eng_auto = 1'b0;
    man_done = 1'b0;
    for (int i = 0; i < N; i++) send_block({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    idle(1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_wait ctl got rdy=%b busy=%b ov=%b want 1 0 0", in_ready, busy, out_valid); end
    n_checks++; if (aes_plain_text !== '0 || aes_cipher_key !== '0) begin n_fail++; $display("FAIL rst_wait_lanes got nonzero, want 0"); end
    exp_q.delete();
    got_q.delete();
    bcnt = 0;
    eng_auto = 1'b1;
    rdy_hold = 1'b0;
    for (int i = 0; i < N; i++) send_block({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    for (int c = 0; c < 50 && !out_valid; c++) idle(1);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_drain_reach got %b want 1", out_valid); end
    rdy_hold = 1'b1;
    idle(2);
    rdy_hold = 1'b0;
    e = exp_q[2];
    n_checks++; if ({out_last, out_data} !== e) begin n_fail++; $display("FAIL rst_drain_idx2 got %h want %h", {out_last, out_data}, e); end
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_data !== '0) begin n_fail++; $display("FAIL rst_drain ctl got rdy=%b busy=%b ov=%b want 1 0 0", in_ready, busy, out_valid); end
    n_checks++; if (aes_plain_text !== '0) begin n_fail++; $display("FAIL rst_drain_lanes got nonzero, want 0"); end
    exp_q.delete();
    got_q.delete();
    bcnt = 0;
    rdy_hold = 1'b1;
    for (int i = 0; i < N; i++) send_block({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    for (int c = 0; c < 200 && got_q.size() < N; c++) @(posedge clk);
    n_checks++;
    if (got_q.size() != N) begin n_fail++; $display("FAIL rst_after_count got %0d want %0d", got_q.size(), N); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL rst_after_out got %h want %h", g, e); end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_back_to_back;
    logic [128:0] e, g;
    rdy_hold = 1'b1;
    for (int i = 0; i < N; i++) send_block({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    send_block(KPT, KKEY, 1'b0);
    n_checks++;
    if (got_q.size() != N) begin n_fail++; $display("FAIL b2b_overlap drained %0d before accept, want %0d", got_q.size(), N); end
    for (int i = 1; i < N; i++) send_block({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    for (int c = 0; c < 200 && got_q.size() < 2 * N; c++) @(posedge clk);
    n_checks++;
    if (got_q.size() != 2 * N) begin n_fail++; $display("FAIL b2b_count got %0d want %0d", got_q.size(), 2 * N); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL b2b_out got %h want %h", g, e); end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    test_reset();
    test_full_batch();
    test_partial();
    test_backpressure();
    test_stale_done();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
